// File: rtl/wrselh_rmw.sv
// Half-word store merge: read the containing word, splice the half into the
// selected lane and write it back. Full-word stores skip the read.
module wrselh_rmw #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_full,
  input  logic                  req_sel,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_data,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, READ, WAIT, WRITE} state_t;

  state_t      state;
  logic        st_sel;
  logic [15:0] st_half;
  logic [31:0] merge_word;

  assign merge_word = st_sel ? {st_half, mem_rdata[15:0]}
                             : {mem_rdata[31:16], st_half};

  // mem_addr doubles as the stored address; mem_wdata is the merge register.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
      st_sel    <= 1'b0;
      st_half   <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= 1'b0;
      done   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_ready && req_valid) begin
            req_ready <= 1'b0;
            mem_addr  <= req_addr;
            st_sel    <= req_sel;
            st_half   <= req_data[15:0];
            mem_en    <= 1'b1;
            if (req_full) begin
              state     <= WRITE;
              mem_we    <= 1'b1;
              mem_wdata <= req_data;
              done      <= 1'b1;
            end else begin
              state <= READ;
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        READ: state <= WAIT;
        WAIT: begin
          state     <= WRITE;
          mem_wdata <= merge_word;
          mem_en    <= 1'b1;
          mem_we    <= 1'b1;
          done      <= 1'b1;
        end
        WRITE: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wrselh_rmw.sv
// Bench for wrselh_rmw: behavioural word memory, directed cases and random
// half/full stores checked against an array-based memory image.
module tb_wrselh_rmw;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          srstn = 1'b0;
  logic          req_valid = 1'b0, req_full = 1'b0, req_sel = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   req_data = '0;
  logic          req_ready, mem_en, mem_we, done;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata = '0;

  int checks = 0, errors = 0, cyc = 0;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  logic        bk_we = 1'b0;
  logic [5:0]  bk_addr = '0;
  logic [31:0] bk_data = '0;

  wrselh_rmw #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .srstn(srstn), .req_valid(req_valid), .req_ready(req_ready),
    .req_full(req_full), .req_sel(req_sel), .req_addr(req_addr), .req_data(req_data),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .done(done));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (bk_we) mem[bk_addr] <= bk_data;
    else if (mem_en) begin
      if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr[5:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("we_without_en", {31'd0, mem_we & ~mem_en}, 32'd0);
    chk("done_without_write", {31'd0, done & ~(mem_en & mem_we)}, 32'd0);
  end

  task automatic bk_write(input logic [5:0] a, input logic [31:0] d);
    bk_we = 1'b1; bk_addr = a; bk_data = d;
    @(negedge clk);
    bk_we = 1'b0;
    ref_mem[a] = d;
  endtask

  // Issue one store starting at a negedge; returns at the negedge where ready is back.
  task automatic do_req(input bit full, input bit sel, input logic [AW-1:0] a,
                        input logic [31:0] d, input bit keep, output int hs);
    logic [31:0] old, exp;
    int n;
    req_valid = 1'b1; req_full = full; req_sel = sel; req_addr = a; req_data = d;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    chk("handshake_ready", {31'd0, req_ready}, 32'd1);
    hs = cyc;
    if (req_ready !== 1'b1) begin req_valid = 1'b0; return; end
    old = ref_mem[a[5:0]];
    if (full)      exp = d;
    else if (sel)  exp = {d[15:0], old[15:0]};
    else           exp = {old[31:16], d[15:0]};
    @(negedge clk);
    req_valid = keep; req_full = $urandom; req_sel = $urandom;
    req_addr = AW'($urandom_range(0, 63)); req_data = $urandom;
    if (!full) begin
      chk("rd_strobe", {29'd0, mem_en, mem_we, done}, 32'b100);
      chk("rd_addr", 32'(mem_addr), 32'(a));
      chk("rd_ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
      chk("wait_idle", {29'd0, mem_en, req_ready, done}, 32'b000);
      @(negedge clk);
    end
    chk("wr_strobe", {28'd0, mem_en, mem_we, done, req_ready}, 32'b1110);
    chk("wr_addr", 32'(mem_addr), 32'(a));
    chk("wr_data", mem_wdata, exp);
    @(negedge clk);
    ref_mem[a[5:0]] = exp;
    chk("ready_back", {29'd0, req_ready, mem_en, done}, 32'b100);
    chk("mem_word", mem[a[5:0]], exp);
  endtask

  int h1, h2;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    req_valid = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 64; i++) bk_write(6'(i), $urandom);
    bk_write(6'h10, 32'h788EFD0C);
    repeat (3) begin
      @(negedge clk);
      chk("rst_outputs", {28'd0, req_ready, mem_en, mem_we, done}, 32'd0);
      chk("rst_addr", 32'(mem_addr), 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
    end
    req_valid = 1'b0;
    srstn = 1'b1;
    #1 chk("rel_ready_low", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("rel_ready_high", {31'd0, req_ready}, 32'd1);

    do_req(1'b0, 1'b0, 16'h10, 32'h00001234, 1'b0, h1);
    chk("low_half", mem[16], 32'h788E1234);
    bk_write(6'h10, 32'h788EFD0C);
    do_req(1'b0, 1'b1, 16'h10, 32'hFFFFABCD, 1'b0, h1);
    chk("high_half", mem[16], 32'hABCDFD0C);
    do_req(1'b1, 1'b0, 16'h20, 32'hDEADBEEF, 1'b0, h1);
    chk("full_bypass", mem[32], 32'hDEADBEEF);

    bk_write(6'h10, 32'h788EFD0C);
    do_req(1'b0, 1'b0, 16'h10, 32'h00001111, 1'b1, h1);
    do_req(1'b0, 1'b1, 16'h10, 32'h00002222, 1'b0, h2);
    chk("b2b_spacing", 32'(h2 - h1), 32'd4);
    chk("b2b_word", mem[16], 32'h22221111);

    bk_write(6'h10, 32'h788EFD0C);
    req_valid = 1'b1; req_full = 1'b0; req_sel = 1'b1; req_addr = 16'h10; req_data = 32'h5555;
    chk("rw_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rw_read", {30'd0, mem_en, mem_we}, 32'b10);
    @(negedge clk);
    srstn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rw_no_write", {29'd0, mem_en, mem_we, done}, 32'd0);
    end
    srstn = 1'b1;
    @(negedge clk);
    chk("rw_ready_back", {31'd0, req_ready}, 32'd1);
    chk("rw_mem_kept", mem[16], 32'h788EFD0C);

    for (int i = 0; i < 24; i++)
      do_req(1'($urandom), 1'($urandom), AW'($urandom_range(0, 7)), $urandom,
             1'($urandom), h1);
    req_valid = 1'b0;
    for (int i = 0; i < 8; i++) chk("final_image", mem[i], ref_mem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
